// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single data-memory port: fixed priority to port 0, starvation guard for port 1.
// Optional grant/conflict performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
  parameter int WIDTH        = 64,
  parameter int AW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             word_we0,
  input  logic             byte_we0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             word_we1,
  input  logic             byte_we1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_word_we,
  output logic             mem_byte_we,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_gnt0,
  output logic [31:0]      perf_gnt1,
  output logic [31:0]      perf_conflict
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [AW-1:0] align8(input logic [AW-1:0] a);
    return {a[AW-1:3], 3'b000};
  endfunction

  logic [3:0]       starve_cnt;
  logic             win0_p0, win1_p0;
  logic             rd0_p0, rd1_p0;
  logic             vld0_p1, vld1_p1;
  logic [WIDTH-1:0] rdata0_p1, rdata1_p1;

  // Stage p0: combinational decision and memory-side drive; reset blocks every grant
  assign win1_p0 = !reset && req1 && (!req0 || (starve_cnt >= LIMIT));
  assign win0_p0 = !reset && req0 && !win1_p0;
  assign gnt0    = win0_p0;
  assign gnt1    = win1_p0;
  assign rd0_p0  = win0_p0 && !word_we0 && !byte_we0;
  assign rd1_p0  = win1_p0 && !word_we1 && !byte_we1;

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_word_we = 1'b0;
    mem_byte_we = 1'b0;
    if (win1_p0) begin
      mem_addr    = align8(addr1);
      mem_wdata   = wdata1;
      mem_word_we = word_we1;
      mem_byte_we = byte_we1 && !word_we1;
    end else if (win0_p0) begin
      mem_addr    = align8(addr0);
      mem_wdata   = wdata0;
      mem_word_we = word_we0;
      mem_byte_we = byte_we0 && !word_we0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      vld0_p1    <= 1'b0;
      vld1_p1    <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      if (!req1 || win1_p0) starve_cnt <= 4'd0;
      else                  starve_cnt <= sat_inc(starve_cnt);
      vld0_p1 <= rd0_p0;
      vld1_p1 <= rd1_p0;
      if (rd0_p0) rdata0_p1 <= mem_rdata;
      if (rd1_p0) rdata1_p1 <= mem_rdata;
    end
  end

  // Stage p1: response registers; masked while reset is high so a read caught by reset is dropped
  assign rvalid0 = vld0_p1 && !reset;
  assign rvalid1 = vld1_p1 && !reset;
  assign rdata0  = reset ? '0 : rdata0_p1;
  assign rdata1  = reset ? '0 : rdata1_p1;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_gnt0     <= 32'd0;
      perf_gnt1     <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (win0_p0)       perf_gnt0     <= perf_gnt0 + 32'd1;
      if (win1_p0)       perf_gnt1     <= perf_gnt1 + 32'd1;
      if (req0 && req1)  perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule
